data_prod_proc_mc: RTL

DATA_PROD_PROC_MC -- requirements
Module: data_prod_proc_mc

---
 rtl/data_prod_proc_mc.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/data_prod_proc_mc.sv
// Multi-channel data producer: round-robin arbiter over per-channel counters, one processing stage, output FIFO.
// Optional beat counter output enabled by defining DATA_PROD_PROC_MC_STATS_EN.
module data_prod_proc_mc #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 4,
    localparam int CH_W  = $clog2(NUM_CH),
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic [1:0]        mode,
    output logic              valid_out,
    input  logic              ready_out,
    output logic [DATA_W-1:0] data_out,
    output logic [CH_W-1:0]   ch_out,
    output logic [LVL_W-1:0]  fifo_level
`ifdef DATA_PROD_PROC_MC_STATS_EN
    ,
    output logic [31:0]       beat_count
`endif
);

    localparam int AW = LVL_W - 1;

    logic [DATA_W-1:0] cnt_q [NUM_CH];
    logic [DATA_W-1:0] cnt_d [NUM_CH];
    logic [CH_W-1:0]   ptr_q, ptr_d;

    logic              stage_valid_q, stage_valid_d;
    logic [DATA_W-1:0] stage_data_q, stage_data_d;
    logic [CH_W-1:0]   stage_ch_q, stage_ch_d;
    logic [1:0]        stage_mode_q, stage_mode_d;

    logic [DATA_W-1:0] mem_data_q [DEPTH];
    logic [CH_W-1:0]   mem_ch_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;

    logic              pop, push, space_ok, gnt_found, grant;
    logic [CH_W-1:0]   gnt_idx, idx;
    logic [LVL_W:0]    occ;
    logic [DATA_W-1:0] stage_result;

    function automatic logic [DATA_W-1:0] proc_word(input logic [DATA_W-1:0] d, input logic [1:0] m);
        case (m)
            2'b00:   return d;
            2'b01:   return d + DATA_W'(1);
            2'b10:   return ~d;
            default: return {d[DATA_W-2:0], d[DATA_W-1]};
        endcase
    endfunction

    always_comb begin
        pop      = (level_q != '0) && ready_out;
        push     = stage_valid_q;
        // occupancy the FIFO will have once the in-flight stage word lands
        occ      = {1'b0, level_q} + (LVL_W+1)'(stage_valid_q) - (LVL_W+1)'(pop);
        space_ok = occ < (LVL_W+1)'(DEPTH);

        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = CH_W'((int'(ptr_q) + i) % NUM_CH);
            if (!gnt_found && ch_en[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx;
            end
        end
        grant = gnt_found && space_ok;

        ptr_d = grant ? CH_W'((int'(gnt_idx) + 1) % NUM_CH) : ptr_q;
        for (int k = 0; k < NUM_CH; k++) begin
            cnt_d[k] = cnt_q[k];
            if (grant && (gnt_idx == CH_W'(k)))
                cnt_d[k] = cnt_q[k] + DATA_W'(1);
        end

        stage_valid_d = grant;
        stage_data_d  = grant ? cnt_q[gnt_idx] : stage_data_q;
        stage_ch_d    = grant ? gnt_idx : stage_ch_q;
        stage_mode_d  = grant ? mode : stage_mode_q;
        stage_result  = proc_word(stage_data_q, stage_mode_q);

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NUM_CH; k++)
                cnt_q[k] <= DATA_W'(k);
            ptr_q         <= '0;
            stage_valid_q <= 1'b0;
            stage_data_q  <= '0;
            stage_ch_q    <= '0;
            stage_mode_q  <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
        end else begin
            cnt_q         <= cnt_d;
            ptr_q         <= ptr_d;
            stage_valid_q <= stage_valid_d;
            stage_data_q  <= stage_data_d;
            stage_ch_q    <= stage_ch_d;
            stage_mode_q  <= stage_mode_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
        end
    end

    // storage needs no reset: outputs are gated by occupancy
    always_ff @(posedge clk) begin
        if (rst && push) begin
            mem_data_q[wr_ptr_q] <= stage_result;
            mem_ch_q[wr_ptr_q]   <= stage_ch_q;
        end
    end

    assign valid_out  = (level_q != '0);
    assign data_out   = valid_out ? mem_data_q[rd_ptr_q] : '0;
    assign ch_out     = valid_out ? mem_ch_q[rd_ptr_q] : '0;
    assign fifo_level = level_q;

`ifdef DATA_PROD_PROC_MC_STATS_EN
    logic [31:0] beat_count_q, beat_count_d;

    always_comb beat_count_d = beat_count_q + 32'(pop);

    always_ff @(posedge clk) begin
        if (!rst) beat_count_q <= '0;
        else      beat_count_q <= beat_count_d;
    end

    assign beat_count = beat_count_q;
`endif

endmodule
